// File: rtl/memory_stage_unit.sv
// memory_stage_unit: memory stage of the 16-bit pipeline; performs loads and stores over a req/ack
// handshake, stalls upstream while an access is outstanding and drives the writeback register.
module memory_stage_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] memData_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_wb,
    output logic              wbs_wb,
    output logic              mm_wb,
    output logic              wm_wb,
    output logic [DATA_W-1:0] alu_result_wb,
    output logic [DATA_W-1:0] mem_data_wb,
    output logic              mem_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wbs_op_q, wbs_op_d, mm_op_q, mm_op_d, wm_op_q, wm_op_d;
    logic [DATA_W-1:0] alu_op_q, alu_op_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              valid_wb_q, valid_wb_d, wbs_wb_q, wbs_wb_d;
    logic              mm_wb_q, mm_wb_d, wm_wb_q, wm_wb_d;
    logic [DATA_W-1:0] alu_result_wb_q, alu_result_wb_d, mem_data_wb_q, mem_data_wb_d;
    logic              mem_err_q, mem_err_d;
    logic              mem_op, done, timeout;

    assign mem_op  = ~ni_in & (wme_in | mm_in);
    assign done    = (state_q == ACCESS) & (mem_ack | (cnt_q == CNT_LAST));
    assign timeout = (state_q == ACCESS) & ~mem_ack & (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            wbs_op_q        <= 1'b0;
            mm_op_q         <= 1'b0;
            wm_op_q         <= 1'b0;
            alu_op_q        <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            valid_wb_q      <= 1'b0;
            wbs_wb_q        <= 1'b0;
            mm_wb_q         <= 1'b0;
            wm_wb_q         <= 1'b0;
            alu_result_wb_q <= '0;
            mem_data_wb_q   <= '0;
            mem_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wbs_op_q        <= wbs_op_d;
            mm_op_q         <= mm_op_d;
            wm_op_q         <= wm_op_d;
            alu_op_q        <= alu_op_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            valid_wb_q      <= valid_wb_d;
            wbs_wb_q        <= wbs_wb_d;
            mm_wb_q         <= mm_wb_d;
            wm_wb_q         <= wm_wb_d;
            alu_result_wb_q <= alu_result_wb_d;
            mem_data_wb_q   <= mem_data_wb_d;
            mem_err_q       <= mem_err_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (mem_op ? ACCESS : IDLE) : (done ? IDLE : ACCESS);
        cnt_d   = (state_q == ACCESS && !done) ? cnt_q + 8'd1 : 8'd0;
    end

    // The op is re-latched every IDLE cycle and therefore frozen for the whole ACCESS.
    always_comb begin
        wbs_op_d    = wbs_op_q;
        mm_op_d     = mm_op_q;
        wm_op_d     = wm_op_q;
        alu_op_d    = alu_op_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q | timeout;
        if (state_q == IDLE) begin
            wbs_op_d        = wbs_in;
            mm_op_d         = mm_in & ~wme_in;
            wm_op_d         = wm_in;
            alu_op_d        = ALUresult_in;
            mem_req_d       = mem_op;
            mem_we_d        = wme_in;
            mem_addr_d      = ALUresult_in[ADDR_W-1:0];
            mem_wdata_d     = memData_in;
            valid_wb_d      = ~ni_in & ~mem_op;
            wbs_wb_d        = ~ni_in & ~mem_op & wbs_in;
            mm_wb_d         = mm_in & ~wme_in;
            wm_wb_d         = wm_in;
            alu_result_wb_d = ALUresult_in;
            mem_data_wb_d   = '0;
        end else begin
            mem_req_d       = ~done;
            valid_wb_d      = done;
            wbs_wb_d        = mem_ack & wbs_op_q;
            mm_wb_d         = mm_op_q;
            wm_wb_d         = wm_op_q;
            alu_result_wb_d = alu_op_q;
            mem_data_wb_d   = (mem_ack && mm_op_q) ? mem_rdata : '0;
        end
    end

    assign stall         = (state_q == ACCESS);
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign valid_wb      = valid_wb_q;
    assign wbs_wb        = wbs_wb_q;
    assign mm_wb         = mm_wb_q;
    assign wm_wb         = wm_wb_q;
    assign alu_result_wb = alu_result_wb_q;
    assign mem_data_wb   = mem_data_wb_q;
    assign mem_err       = mem_err_q;
endmodule
